// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/parity/stop, checks the device ack.
// Lines are driven only via active-high output enables; the pin pads implement the open-drain tie-low.
module ps2_host_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH  = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TMO  = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int CMAX = (INH > TMO) ? INH : TMO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RELEASE, BITS, ACK, WAITIDLE
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] flt_cnt;
  logic          fall, data_s;
  logic [CW-1:0] tcnt;
  logic [3:0]    n;
  logic [9:0]    frame;
  logic          data_q;
  logic          done_q, error_q;
  logic          done_nx, error_nx;
  logic          accept, inh_last, tmo_hit;

  // Input synchronizers and clock glitch filter
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      flt_cnt    <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt_d & ~clk_filt;
  assign data_s   = data_sync[1];
  assign accept   = (state == IDLE) && tx_start && !done_q && !error_q;
  assign inh_last = (tcnt == CW'(INH - 1));
  assign tmo_hit  = (tcnt == CW'(TMO - 1)) && !fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nx;
      done_q  <= done_nx;
      error_q <= error_nx;
    end
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    error_nx = 1'b0;
    case (state)
      IDLE:    if (accept) state_nx = INHIBIT;
      INHIBIT: if (inh_last) state_nx = RELEASE;
      RELEASE: begin
        if (tmo_hit) begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end else begin
          state_nx = BITS;
        end
      end
      BITS: begin
        if (tmo_hit) begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end else if (fall && n == 4'd9) begin
          state_nx = ACK;
        end
      end
      ACK: begin
        if (tmo_hit || (fall && data_s)) begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end else if (fall) begin
          state_nx = WAITIDLE;
        end
      end
      WAITIDLE: begin
        if (tmo_hit) begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end else if (clk_filt && data_s) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame, edge counter and the shared inhibit/timeout cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt   <= '0;
      n      <= '0;
      frame  <= '0;
      data_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            frame  <= {1'b1, ~^tx_data, tx_data};
            tcnt   <= '0;
            n      <= '0;
            data_q <= 1'b1;
          end
        end
        INHIBIT: tcnt <= inh_last ? '0 : tcnt + 1'b1;
        default: tcnt <= fall ? '0 : tcnt + 1'b1;
      endcase
      if (state == BITS && fall) begin
        n      <= n + 1'b1;
        data_q <= ~frame[n];
      end
    end
  end

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    busy        = (state != IDLE);
    case (state)
      INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = inh_last;
      end
      RELEASE:   ps2_data_oe = 1'b1;
      BITS, ACK: ps2_data_oe = data_q;
      default:   ps2_data_oe = 1'b0;
    endcase
  end

  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model (80-cycle bit period at 1 MHz).
// Scaled timing: INH = 100 cycles, TMO = 2000 cycles.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, error;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .CLK_HZ(1000000), .INHIBIT_US(100), .TIMEOUT_US(2000), .FILTER_LEN(8)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_clk_oe", ps2_clk_oe, 1);
  endtask

  // Device side: waits for the host to release the clock, then clocks 11 bits.
  task automatic device(input bit ack, input bit glitch, input int rst_at,
                        output logic [9:0] oe_seen);
    int w;
    oe_seen = '0;
    w = 0;
    while (ps2_clk_oe && w < 1000) begin
      cyc(1);
      w++;
    end
    check("release_seen", ps2_clk_oe, 0);
    if (ps2_clk_oe) return;
    check("start_bit", ps2_data_oe, 1);
    cyc(20);
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      cyc(15);
      if (i == rst_at) begin
        rst = 1'b1;
        cyc(1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      cyc(15);
      if (i <= 10) oe_seen[i-1] = ps2_data_oe;
      cyc(10);
      dev_clk = 1'b1;
      if (glitch && i >= 2 && i <= 9) begin
        cyc(10);
        dev_clk = 1'b0;
        cyc(3);
        dev_clk = 1'b1;
        cyc(27);
      end else if (i == 10) begin
        cyc(20);
        dev_data = ~ack;
        cyc(20);
      end else begin
        cyc(40);
      end
    end
    dev_data = 1'b1;
  endtask

  logic [9:0] oe;
  int d0, e0, w, n_inh, n_tmo;

  initial begin
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    cyc(4);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_error0", error, 0);
    check("rst_clk_oe0", ps2_clk_oe, 0);
    check("rst_data_oe0", ps2_data_oe, 0);
    rst = 1'b0;
    cyc(4);

    // 0xED: parity 1, oe = ~frame
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    device(1'b1, 1'b0, 0, oe);
    check("ed_frame_oe", oe, 10'h012);
    cyc(10);
    check("ed_done", done_cnt - d0, 1);
    check("ed_error", err_cnt - e0, 0);
    check("ed_idle_busy", busy, 0);
    check("ed_idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);

    // 0x00: parity bit 1 shown released; tx_start on the done cycle is ignored
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    device(1'b1, 1'b0, 0, oe);
    check("zero_frame_oe", oe, 10'h0FF);
    w = 0;
    while (!done && w < 200) begin
      cyc(1);
      w++;
    end
    check("zero_done_seen", done, 1);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
    check("start_on_done_ignored", busy, 0);
    cyc(5);
    check("still_idle", busy, 0);
    check("zero_done", done_cnt - d0, 1);
    check("zero_error", err_cnt - e0, 0);

    // Silent device: inhibit length and timeout
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12);
    n_inh = 1;
    while (ps2_clk_oe && n_inh < 1000) begin
      cyc(1);
      if (ps2_clk_oe) n_inh++;
    end
    check("inhibit_cycles", n_inh, 100);
    n_tmo = 0;
    while (!error && n_tmo < 5000) begin
      cyc(1);
      n_tmo++;
    end
    check("timeout_cycles", n_tmo, 2000);
    check("tmo_oes", {ps2_clk_oe, ps2_data_oe}, 0);
    check("tmo_busy", busy, 0);
    cyc(2);
    check("tmo_done", done_cnt - d0, 0);
    check("tmo_error", err_cnt - e0, 1);

    // Missing acknowledge, then a new request is taken
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C);
    device(1'b0, 1'b0, 0, oe);
    check("noack_frame_oe", oe, 10'h0C3);
    cyc(20);
    check("noack_error", err_cnt - e0, 1);
    check("noack_done", done_cnt - d0, 0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    device(1'b1, 1'b0, 0, oe);
    cyc(10);
    check("after_noack_done", done_cnt - d0, 1);

    // Clock glitches during the data bits
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5);
    device(1'b1, 1'b1, 0, oe);
    check("glitch_frame_oe", oe, 10'h05A);
    cyc(10);
    check("glitch_done", done_cnt - d0, 1);
    check("glitch_error", err_cnt - e0, 0);

    // Reset mid-frame, then a clean 0xF4
    d0 = done_cnt; e0 = err_cnt;
    send(8'h81);
    device(1'b1, 1'b0, 5, oe);
    cyc(50);
    send(8'hF4);
    device(1'b1, 1'b0, 0, oe);
    check("f4_frame_oe", oe, 10'h10B);
    cyc(10);
    check("f4_done", done_cnt - d0, 1);
    check("f4_error", err_cnt - e0, 0);

    check("done_error_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
